fifo_arb: RTL

FIFO_ARB -- requirements
Module: fifo_arb

---
 rtl/fifo_arb_if.sv | 32 +++
 rtl/fifo_arb.sv | 112 +++++++++++
 2 files changed

// File: rtl/fifo_arb_if.sv
// fifo_arb_if -- requester/FIFO-side bundle for fifo_arb.
//   RQ_STB  [3:0]         per-requester write strobe
//   RQ_DAT  [4*WIDTH-1:0] per-requester data, requester i at [i*WIDTH +: WIDTH]
//   RQ_ACK  [3:0]         per-requester accept (word taken this cycle)
//   FI_STB                write strobe to the shared FIFO
//   FI_DAT  [WIDTH-1:0]   write data to the shared FIFO
//   FI_BSY                shared FIFO full; no write taken while high
//   GNT     [1:0]         index of the granted requester
//   GNT_VLD               a grant is currently held
// slave is the arbiter side, master is the requester/FIFO side.
interface fifo_arb_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         RQ_STB;
  logic [4*WIDTH-1:0] RQ_DAT;
  logic [3:0]         RQ_ACK;
  logic               FI_STB;
  logic [WIDTH-1:0]   FI_DAT;
  logic               FI_BSY;
  logic [1:0]         GNT;
  logic               GNT_VLD;

  modport slave (
    input  RQ_STB, RQ_DAT, FI_BSY,
    output RQ_ACK, FI_STB, FI_DAT, GNT, GNT_VLD
  );

  modport master (
    output RQ_STB, RQ_DAT, FI_BSY,
    input  RQ_ACK, FI_STB, FI_DAT, GNT, GNT_VLD
  );
endinterface

// File: rtl/fifo_arb.sv
// fifo_arb -- four-requester round-robin arbiter feeding one shared FIFO.
// A winner holds the grant for up to BURST accepted words, or until it drops
// its strobe; the next winner is chosen in the same cycle so back-to-back
// bursts have no idle gap.
// Ports:
//   CLK   single clock, rising edge
//   RST   asynchronous active-low reset
//   bus   fifo_arb_if.slave (requester strobes/data/acks, FIFO write side,
//         grant status). The interface WIDTH must equal this WIDTH.
module fifo_arb #(
  parameter int WIDTH = 8,
  parameter int BURST = 4   // 1..16
) (
  input  logic       CLK,
  input  logic       RST,
  fifo_arb_if.slave  bus
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic       fi_stb;
  logic       any_req;
  logic       grant_end;

  // First requester with its strobe high, searching base+1 .. base+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] req);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req   = |bus.RQ_STB;
  assign fi_stb    = (state_q == XFER) && bus.RQ_STB[gnt_q] && !bus.FI_BSY;
  // Burst exhausted on this write, or the holder withdrew its strobe.
  assign grant_end = (fi_stb && (cnt_q == LAST_CNT)) || !bus.RQ_STB[gnt_q];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = rr_pick(ptr_q, bus.RQ_STB);
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (grant_end) begin
          // The ending holder becomes the new round-robin pointer, and the
          // search starts just after it in this same cycle.
          ptr_d = gnt_q;
          if (any_req) begin
            gnt_d = rr_pick(gnt_q, bus.RQ_STB);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (fi_stb) begin
          cnt_d = cnt_q + 4'd1;
        end
        // FI_BSY high with the strobe still up: everything holds (stall).
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      ptr_q   <= 2'd3;   // requester 0 gets first priority after reset
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.FI_STB  = fi_stb;
  assign bus.FI_DAT  = bus.RQ_DAT[gnt_q*WIDTH +: WIDTH];
  assign bus.RQ_ACK  = fi_stb ? (4'b0001 << gnt_q) : 4'b0000;
  assign bus.GNT     = gnt_q;
  assign bus.GNT_VLD = (state_q == XFER);

endmodule
